// File: rtl/ram_param_clr.sv
// Parametrised single-port synchronous RAM with a post-reset clear sweep,
// selectable read-during-write behaviour and a memory-mapped LED mirror.
module ram_param_clr #(
  parameter int          WIDTH          = 16,
  parameter int          ADDR_WIDTH     = 15,
  parameter int unsigned LED_ADDR       = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          WRITE_FIRST    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  load,
  output logic [WIDTH-1:0]      out,
  output logic [WIDTH-1:0]      led_out,
  output logic                  busy
);

  localparam int                    DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LED_A = ADDR_WIDTH'(LED_ADDR);

  // ST_CLEAR is encoded as 1 so busy is the state flop itself.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [WIDTH-1:0]      led_q, led_d;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      rd_data;

  assign rd_data = mem[addr];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    out_d      = out_q;
    led_d      = led_q;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = in;

    if (reset) begin
      state_d    = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr_d = '0;
      out_d      = '0;
      led_d      = '0;
    end else if (state_q == ST_CLEAR) begin
      mem_we     = 1'b1;
      mem_waddr  = clr_addr_q;
      mem_wdata  = '0;
      clr_addr_d = clr_addr_q + 1'b1;
      out_d      = '0;
      if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_RUN;
      end
    end else if (load) begin
      mem_we = 1'b1;
      out_d  = WRITE_FIRST ? in : rd_data;
      if (addr == LED_A) begin
        led_d = in;
      end
    end else begin
      out_d = rd_data;
    end
  end

  always_ff @(posedge clock) begin
    state_q    <= state_d;
    clr_addr_q <= clr_addr_d;
    out_q      <= out_d;
    led_q      <= led_d;
  end

  // The array has no reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out     = out_q;
  assign led_out = led_q;
  assign busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed and randomized checks of ram_param_clr across four parameter sets,
// with a sparse associative-array reference memory for the random traffic.
module tb_ram_param_clr;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance a: default geometry, LED at the top word
  logic        a_reset, a_load, a_busy;
  logic [15:0] a_in, a_out, a_led;
  logic [14:0] a_addr;
  // Instance b: 16-word clear-on-reset
  logic        b_reset, b_load, b_busy;
  logic [15:0] b_in, b_out, b_led;
  logic [3:0]  b_addr;
  // Instance c: read-first
  logic        c_reset, c_load, c_busy;
  logic [15:0] c_in, c_out, c_led;
  logic [7:0]  c_addr;
  // Instance d: contents kept across reset
  logic        d_reset, d_load, d_busy;
  logic [15:0] d_in, d_out, d_led;
  logic [3:0]  d_addr;

  ram_param_clr #(.WIDTH(16), .ADDR_WIDTH(15), .LED_ADDR(32'h7FFF),
                  .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b1)) u_a (
    .clock(clock), .reset(a_reset), .in(a_in), .addr(a_addr), .load(a_load),
    .out(a_out), .led_out(a_led), .busy(a_busy));

  ram_param_clr #(.WIDTH(16), .ADDR_WIDTH(4), .LED_ADDR(0),
                  .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b1)) u_b (
    .clock(clock), .reset(b_reset), .in(b_in), .addr(b_addr), .load(b_load),
    .out(b_out), .led_out(b_led), .busy(b_busy));

  ram_param_clr #(.WIDTH(16), .ADDR_WIDTH(8), .LED_ADDR(0),
                  .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b0)) u_c (
    .clock(clock), .reset(c_reset), .in(c_in), .addr(c_addr), .load(c_load),
    .out(c_out), .led_out(c_led), .busy(c_busy));

  ram_param_clr #(.WIDTH(16), .ADDR_WIDTH(4), .LED_ADDR(0),
                  .CLEAR_ON_RESET(1'b0), .WRITE_FIRST(1'b1)) u_d (
    .clock(clock), .reset(d_reset), .in(d_in), .addr(d_addr), .load(d_load),
    .out(d_out), .led_out(d_led), .busy(d_busy));

  logic [15:0] ref_mem [int unsigned];
  logic [15:0] ref_led;

  function automatic logic [15:0] ref_read(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (b_busy === 1'b1 && n < 64);
  endtask

  task automatic apply_stimulus_a(input logic ld, input logic [14:0] ad,
                                  input logic [15:0] dv);
    a_load = ld;
    a_addr = ad;
    a_in   = dv;
    tick();
    if (ld) begin
      ref_mem[int'(ad)] = dv;
      if (ad == 15'h7FFF) ref_led = dv;
    end
  endtask

  initial begin
    int n;
    int wait_n;
    logic [14:0] aa, ab;
    logic [15:0] va, vb;

    a_reset = 1; a_load = 0; a_in = 0; a_addr = 0;
    b_reset = 1; b_load = 0; b_in = 0; b_addr = 0;
    c_reset = 1; c_load = 0; c_in = 0; c_addr = 0;
    d_reset = 1; d_load = 0; d_in = 0; d_addr = 0;
    ref_led = 16'h0000;
    tick();
    check_output("rst_a_busy", 32'(a_busy), 32'd1);
    check_output("rst_a_out",  32'(a_out),  32'h0);
    check_output("rst_a_led",  32'(a_led),  32'h0);
    check_output("rst_d_busy", 32'(d_busy), 32'd0);
    check_output("rst_d_out",  32'(d_out),  32'h0);
    a_reset = 0; b_reset = 0; c_reset = 0; d_reset = 0;

    // Clear sweep on the 16-word instance
    count_busy_b(n);
    check_output("clr_b_edges", 32'(n), 32'd16);
    b_load = 1; b_addr = 4'd5; b_in = 16'hBEEF;
    tick();
    check_output("b_wr_beef", 32'(b_out), 32'hBEEF);
    b_load = 0;
    tick();
    check_output("b_rd_beef", 32'(b_out), 32'hBEEF);
    b_reset = 1;
    tick();
    check_output("b_rst_out", 32'(b_out), 32'h0);
    b_reset = 0;
    count_busy_b(n);
    check_output("clr_b_edges2", 32'(n), 32'd16);
    b_addr = 4'd5;
    tick();
    check_output("b_rd5_cleared", 32'(b_out), 32'h0);

    // Reset mid-clear, with an ignored load while busy
    b_load = 1; b_addr = 4'd2; b_in = 16'h1111;
    tick();
    b_load = 0;
    b_reset = 1;
    tick();
    b_reset = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("b_midclr_busy", 32'(b_busy), 32'd1);
    end
    b_reset = 1;
    tick();
    check_output("b_rerst_busy", 32'(b_busy), 32'd1);
    b_reset = 0;
    b_load = 1; b_addr = 4'd2; b_in = 16'h3333;
    count_busy_b(n);
    check_output("clr_b_restart", 32'(n), 32'd16);
    check_output("b_busy_out0", 32'(b_out), 32'h0);
    b_load = 0; b_addr = 4'd2;
    tick();
    check_output("b_rd2_ignored", 32'(b_out), 32'h0);

    // Read-first instance
    wait_n = 0;
    while (c_busy !== 1'b0 && wait_n < 400) begin tick(); wait_n++; end
    check_output("c_clear_done", 32'(c_busy), 32'd0);
    c_load = 1; c_addr = 8'h10; c_in = 16'h1234;
    tick();
    check_output("c_wr1_old", 32'(c_out), 32'h0);
    c_in = 16'h5678;
    tick();
    check_output("c_wr2_old", 32'(c_out), 32'h1234);
    c_load = 0;
    tick();
    check_output("c_rd_new", 32'(c_out), 32'h5678);

    // Contents preserved across reset
    d_load = 1; d_addr = 4'd3; d_in = 16'hCAFE;
    tick();
    check_output("d_wr", 32'(d_out), 32'hCAFE);
    d_load = 0; d_reset = 1;
    tick();
    check_output("d_rst_busy", 32'(d_busy), 32'd0);
    check_output("d_rst_out",  32'(d_out),  32'h0);
    d_reset = 0;
    tick();
    check_output("d_post_busy", 32'(d_busy), 32'd0);
    check_output("d_rd_keep",   32'(d_out),  32'hCAFE);

    // Full-size instance: LED mirror then random write/read pairs
    wait_n = 0;
    while (a_busy !== 1'b0 && wait_n < 40000) begin tick(); wait_n++; end
    check_output("a_clear_done", 32'(a_busy), 32'd0);
    apply_stimulus_a(1'b1, 15'h7FFF, 16'h00A5);
    check_output("led_wr_out", 32'(a_out), 32'h00A5);
    check_output("led_wr",     32'(a_led), 32'h00A5);
    apply_stimulus_a(1'b1, 15'h7FFE, 16'hFFFF);
    check_output("led_other",  32'(a_led), 32'h00A5);
    apply_stimulus_a(1'b0, 15'h7FFF, 16'h0000);
    check_output("led_rd_out", 32'(a_out), 32'h00A5);
    check_output("led_rd",     32'(a_led), 32'h00A5);

    for (int i = 0; i < 128; i++) begin
      aa = 15'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? aa : 15'($urandom);
      va = 16'($urandom);
      vb = 16'($urandom);
      apply_stimulus_a(1'b1, aa, va);
      check_output("rnd_wr_a", 32'(a_out), 32'(va));
      apply_stimulus_a(1'b1, ab, vb);
      check_output("rnd_wr_b", 32'(a_out), 32'(vb));
      apply_stimulus_a(1'b0, aa, 16'h0);
      check_output("rnd_rd_a", 32'(a_out), 32'(ref_read(int'(aa))));
      apply_stimulus_a(1'b0, ab, 16'h0);
      check_output("rnd_rd_b", 32'(a_out), 32'(ref_read(int'(ab))));
      check_output("rnd_led",  32'(a_led), 32'(ref_led));
    end

    a_reset = 1; a_load = 1; a_addr = 15'h7FFF; a_in = 16'h5A5A;
    tick();
    check_output("a_rst_led",  32'(a_led),  32'h0);
    check_output("a_rst_out",  32'(a_out),  32'h0);
    check_output("a_rst_busy", 32'(a_busy), 32'd1);
    a_reset = 0; a_load = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_param_clr.md
Name: ram_param_clr

Overview:
Parametrised successor to the fixed 32K x 16 main RAM.
- Single-port synchronous RAM with configurable data width and depth.
- Selectable read-during-write mode.
- Hardware clear sequencer that zeroes the whole array after reset, with a busy flag.
- Memory-mapped LED mirror register.
- Sits between the CPU data bus and the board LEDs, replacing the fixed-size RAM.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_WIDTH, 15, address width; DEPTH = 2**ADDR_WIDTH words.
- LED_ADDR, 0, word address whose accepted writes are mirrored to led_out.
- CLEAR_ON_RESET, 1, 1 = sweep the array to zero after reset; 0 = contents preserved across reset.
- WRITE_FIRST, 1, 1 = out shows the new data on a write; 0 = out shows the old data on a write.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- addr  input  ADDR_WIDTH  word address.
- load  input  1  write enable; sampled on rising edge.
- out  output  WIDTH  registered read data.
- led_out  output  WIDTH  last value accepted at LED_ADDR.
- busy  output  1  high while the clear sequence runs; accesses are ignored.

Behaviour:
- Reset:
  - One clock with reset high, sampled at a rising edge.
  - Result: out=0, led_out=0, clr_addr=0, state=CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
  - busy=1 in CLEAR, 0 in RUN.
  - While reset stays high, the block holds these values and no array write occurs.
- States: CLEAR, RUN.
- CLEAR:
  - On each edge with reset low: mem[clr_addr]<=0, clr_addr<=clr_addr+1.
  - On the edge that writes DEPTH-1: state<=RUN, busy<=0.
  - busy is high for exactly DEPTH edges after reset deassertion.
  - load, in and addr are ignored; out and led_out hold 0.
- RUN, accepted access = rising edge with reset low:
  - load=1: mem[addr]<=in.
    - out<=in if WRITE_FIRST=1.
    - out<=previous mem[addr] if WRITE_FIRST=0.
  - load=0: out<=mem[addr].
  - Read latency: 1 clock. out changes only at rising edges and holds between them.
- LED mirror:
  - Accepted write with addr==LED_ADDR: led_out<=in on the same edge.
  - Reads never change led_out.
  - led_out does not track the clear sweep; it is cleared by reset only.
- Reset mid-clear: clr_addr returns to 0 and the full sweep restarts; busy stays high with no glitch.
- Reset mid-RUN:
  - CLEAR_ON_RESET=1: re-enters CLEAR.
  - CLEAR_ON_RESET=0: array contents are retained; only out and led_out are zeroed.
- Reset and load together: reset wins; no write occurs.
- Address wrap: addr is exactly ADDR_WIDTH bits, so all values are valid; there is no out-of-range case.
- Back-to-back writes to the same address: the last write wins; the next read returns it.
- No combinational path from inputs to outputs.

Test Plan:
1. Clear sweep (ADDR_WIDTH=4, CLEAR_ON_RESET=1):
   - Stimulus: write 0xBEEF to addr 5, then pulse reset 1 cycle.
   - Required: busy high for exactly 16 edges, then low; read addr 5 -> out=0x0000 one clock later.
2. Write then read, WRITE_FIRST=1 (defaults):
   - Stimulus: 128 random pairs: write val_a@addr_a, write val_b@addr_b, read addr_a, read addr_b.
   - Required: out=val_a after the first write edge; read addr_a returns val_b if addrs are equal, else val_a; read addr_b returns val_b.
3. WRITE_FIRST=0:
   - Stimulus: write 0x1234@0x0010, then write 0x5678@0x0010.
   - Required: out=0x1234 after the second write edge; next read -> 0x5678.
4. LED mirror (LED_ADDR=0x7FFF):
   - Stimulus: write 0x00A5@0x7FFF, write 0xFFFF@0x7FFE, read 0x7FFF.
   - Required: led_out=0x00A5 throughout; reset -> led_out=0.
5. Reset mid-clear (ADDR_WIDTH=4):
   - Stimulus: reassert reset on the 7th busy cycle.
   - Required: busy never drops; total busy = 16 edges after the final deassertion.
   - Stimulus: load=1 with in=0x3333@2 during busy.
   - Required: that load is ignored; read addr 2 -> 0.
6. CLEAR_ON_RESET=0:
   - Stimulus: write 0xCAFE@3, reset.
   - Required: busy stays 0; out=0 after reset; read addr 3 -> 0xCAFE.
